// File: rtl/jt10_adpcm_enc.sv
// ---------------------------------------------------------------------------
// jt10_adpcm_enc
//   Single-channel ADPCM-A encoder. Takes 16-bit signed PCM samples and emits
//   4-bit ADPCM-A codes. It carries its own copy of the decoder's predictor
//   and step, updated with the same arithmetic as jt10_adpcm_comb, so a
//   decoder fed with these codes rebuilds exactly the waveform in 'pred'.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous reset, active low
//   cen        clock enable; nothing changes on an edge with cen=0
//   clr        synchronous predictor clear, highest priority on a cen edge
//   pcm_in     signed PCM sample, captured when in_valid && in_ready
//   in_valid   pcm_in is valid
//   in_ready   encoder is idle and will accept a sample
//   code       ADPCM-A code, [3]=sign, [2:0]=magnitude
//   out_valid  code is valid, held until out_ready on a cen edge
//   out_ready  sink accepts the code
//   pred       predictor after the current code (decoder's next pcm)
//   step       step size after the current code
// ---------------------------------------------------------------------------
module jt10_adpcm_enc #(
  parameter int STEP_MIN = 127,
  parameter int STEP_MAX = 24576
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cen,
  input  logic        clr,
  input  logic [15:0] pcm_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  code,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] pred,
  output logic [14:0] step
);

  localparam logic [14:0] STEP_MIN15 = 15'(STEP_MIN);
  localparam logic [14:0] STEP_MAX15 = 15'(STEP_MAX);
  localparam logic [16:0] STEP_MIN17 = 17'(STEP_MIN);
  localparam logic [16:0] STEP_MAX17 = 17'(STEP_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_DIFF, S_B2, S_B1, S_B0, S_UPD, S_OUT
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pcm_q, pcm_d;
  logic [18:0] t_q, t_d;
  logic        sgn_q, sgn_d;
  logic [2:0]  m_q, m_d;
  logic [3:0]  code_q, code_d;
  logic        out_valid_q, out_valid_d;
  logic        in_ready_q, in_ready_d;
  logic [15:0] pred_q, pred_d;
  logic [14:0] step_q, step_d;

  // Datapath temporaries, recomputed every cycle from the registered state
  logic [16:0] dif, dif_abs;
  logic [18:0] step_x4, step_x2, step_x1;
  logic [18:0] delta_full;
  logic [15:0] delta, sum;
  logic [7:0]  mul;
  logic [22:0] prod;
  logic [16:0] ns;

  // Next-state logic. The magnitude is found by a three-step restoring
  // division of 4*|dif| by step (one bit per state), which gives
  // min(7, floor(4*|dif|/step)) with no rounding. The UPD state then applies
  // the decoder's predictor/step update so both sides stay in lock-step.
  always_comb begin
    state_d     = state_q;
    pcm_d       = pcm_q;
    t_d         = t_q;
    sgn_d       = sgn_q;
    m_d         = m_q;
    code_d      = code_q;
    out_valid_d = out_valid_q;
    pred_d      = pred_q;
    step_d      = step_q;

    dif     = {pcm_q[15], pcm_q} - {pred_q[15], pred_q};
    dif_abs = dif[16] ? (17'd0 - dif) : dif;
    step_x4 = {2'b00, step_q, 2'b00};
    step_x2 = {3'b000, step_q, 1'b0};
    step_x1 = {4'b0000, step_q};

    // delta can exceed 32767; the decoder keeps the 16-bit wrap, so do we
    delta_full = {4'b0000, step_q} * {15'd0, m_q, 1'b1};
    delta      = 16'(delta_full >> 3);
    sum        = sgn_q ? (pred_q - delta) : (pred_q + delta);

    case (m_q)
      3'd4:    mul = 8'd77;
      3'd5:    mul = 8'd102;
      3'd6:    mul = 8'd128;
      3'd7:    mul = 8'd153;
      default: mul = 8'd57;
    endcase
    prod = {8'd0, step_q} * {15'd0, mul};
    ns   = 17'(prod >> 6);

    if (cen) begin
      if (clr) begin
        state_d     = S_IDLE;
        code_d      = 4'd0;
        out_valid_d = 1'b0;
        pred_d      = 16'd0;
        step_d      = STEP_MIN15;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (in_valid) begin
              pcm_d   = pcm_in;
              state_d = S_DIFF;
            end
          end
          S_DIFF: begin
            sgn_d   = dif[16];
            t_d     = {dif_abs, 2'b00};
            m_d     = 3'd0;
            state_d = S_B2;
          end
          S_B2: begin
            if (t_q >= step_x4) begin
              m_d[2] = 1'b1;
              t_d    = t_q - step_x4;
            end
            state_d = S_B1;
          end
          S_B1: begin
            if (t_q >= step_x2) begin
              m_d[1] = 1'b1;
              t_d    = t_q - step_x2;
            end
            state_d = S_B0;
          end
          S_B0: begin
            m_d[0]  = (t_q >= step_x1);
            state_d = S_UPD;
          end
          S_UPD: begin
            code_d = {sgn_q, m_q};
            // Saturate only when the sign of the move matches the old
            // predictor's sign and the result flipped sign
            if ((sgn_q == pred_q[15]) && (sum[15] != sgn_q))
              pred_d = sgn_q ? 16'h8000 : 16'h7FFF;
            else
              pred_d = sum;
            if (ns < STEP_MIN17)
              step_d = STEP_MIN15;
            else if (ns > STEP_MAX17)
              step_d = STEP_MAX15;
            else
              step_d = ns[14:0];
            out_valid_d = 1'b1;
            state_d     = S_OUT;
          end
          S_OUT: begin
            if (out_ready) begin
              out_valid_d = 1'b0;
              state_d     = S_IDLE;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    in_ready_d = (state_d == S_IDLE);
  end

  // State register. Reset is asynchronous so it can abort a conversion at
  // any point; everything else moves only on cen edges via the _d logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pcm_q       <= 16'd0;
      t_q         <= 19'd0;
      sgn_q       <= 1'b0;
      m_q         <= 3'd0;
      code_q      <= 4'd0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      pred_q      <= 16'd0;
      step_q      <= STEP_MIN15;
    end else begin
      state_q     <= state_d;
      pcm_q       <= pcm_d;
      t_q         <= t_d;
      sgn_q       <= sgn_d;
      m_q         <= m_d;
      code_q      <= code_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      pred_q      <= pred_d;
      step_q      <= step_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign code      = code_q;
  assign out_valid = out_valid_q;
  assign pred      = pred_q;
  assign step      = step_q;

endmodule

// File: tb/tb_jt10_adpcm_enc.sv
// ---------------------------------------------------------------------------
// tb_jt10_adpcm_enc
//   Self-checking bench for the ADPCM-A encoder. Expected codes come from a
//   reference model that divides 4*|dif| by step directly, and predictor/step
//   tracking comes from a decoder model that rebuilds the waveform from the
//   codes alone.
// ---------------------------------------------------------------------------
module tb_jt10_adpcm_enc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cen = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] pcm_in = 16'd0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic [3:0]  code;
  logic        out_valid;
  logic [15:0] pred;
  logic [14:0] step;

  int tests = 0;
  int failed = 0;

  // Encoder-side reference state and an independent decoder model
  int mod_pred, mod_step;
  int dec_pred, dec_step;

  typedef struct {
    int pcm;
    int exp_code;
    int exp_pred;
    int exp_step;
  } vec_t;

  vec_t vecs[4];

  jt10_adpcm_enc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cen       (cen),
    .clr       (clr),
    .pcm_in    (pcm_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .code      (code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pred      (pred),
    .step      (step)
  );

  // 100 MHz clock
  always #5 clk = ~clk;

  // Hard stop so a wedged handshake can never hang the run
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic int mul_of(input int m);
    case (m)
      4: return 77;
      5: return 102;
      6: return 128;
      7: return 153;
      default: return 57;
    endcase
  endfunction

  // Decoder update rule: new predictor and step from one code
  task automatic model_update(input int c, inout int p, inout int s);
    int m, sg, delta, pu, sum, ns;
    m     = c & 7;
    sg    = (c >> 3) & 1;
    delta = (((2 * m + 1) * s) >> 3) & 16'hFFFF;
    pu    = p & 16'hFFFF;
    sum   = sg ? ((pu - delta) & 16'hFFFF) : ((pu + delta) & 16'hFFFF);
    if (sg == ((pu >> 15) & 1) && ((sum >> 15) & 1) != sg)
      p = sg ? -32768 : 32767;
    else
      p = (sum >= 32768) ? sum - 65536 : sum;
    ns = (s * mul_of(m)) >> 6;
    if (ns < 127) s = 127;
    else if (ns > 24576) s = 24576;
    else s = ns;
  endtask

  // Ideal encoder decision: magnitude = min(7, floor(4|dif|/step))
  function automatic int model_code(input int sample, input int p, input int s);
    int dif, a, m;
    dif = sample - p;
    a   = (dif < 0) ? -dif : dif;
    m   = (4 * a) / s;
    if (m > 7) m = 7;
    return ((dif < 0) ? 8 : 0) | m;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    mod_pred = 0; mod_step = 127;
    dec_pred = 0; dec_step = 127;
  endtask

  task automatic do_clr();
    cen = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_reset();
  endtask

  // Push one sample through the full handshake, optionally with random cen
  // gaps, and return what the encoder produced plus its accept->valid latency
  task automatic applyStimulus(input int sample, input bit rand_cen,
                               output int c, output int p, output int s,
                               output int lat);
    bit accepted, done;
    int n;
    c = -1; p = 0; s = 0; lat = -1;
    pcm_in   = 16'(sample);
    in_valid = 1'b1;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 200) begin
      cen = rand_cen ? ($urandom_range(0, 3) != 0) : 1'b1;
      accepted = in_ready && cen;
      tick();
      n++;
    end
    in_valid = 1'b0;
    pcm_in   = 16'($urandom);
    if (!accepted) begin
      checkOutput("accept_timeout", 0, 1);
      return;
    end
    n = 0;
    while (!out_valid && n < 200) begin
      cen = rand_cen ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      n++;
    end
    if (!out_valid) begin
      checkOutput("out_valid_timeout", 0, 1);
      return;
    end
    lat = n;
    c = int'(code);
    p = int'($signed(pred));
    s = int'(step);
    out_ready = 1'b1;
    done = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      cen  = rand_cen ? ($urandom_range(0, 3) != 0) : 1'b1;
      done = cen;
      tick();
      n++;
    end
    out_ready = 1'b0;
    cen = 1'b1;
  endtask

  // One sample checked against the encoder model, and optionally against
  // the decoder model driven by the code the DUT actually produced
  task automatic run_sample(input int sample, input bit rand_cen, input bit use_dec,
                            input string tag, output int dut_pred);
    int exp_c, c, p, s, lat;
    exp_c = model_code(sample, mod_pred, mod_step);
    model_update(exp_c, mod_pred, mod_step);
    applyStimulus(sample, rand_cen, c, p, s, lat);
    dut_pred = p;
    checkOutput({tag, "_code"}, c, exp_c);
    checkOutput({tag, "_pred"}, p, mod_pred);
    checkOutput({tag, "_step"}, s, mod_step);
    if (use_dec && c >= 0) begin
      model_update(c, dec_pred, dec_step);
      checkOutput({tag, "_dec_pred"}, p, dec_pred);
    end
  endtask

  initial begin
    int c, p, s, lat, dp, prev, viol, bad, extra, hc, hp, hs, exp_c, smp;

    vecs[0] = '{pcm:  1000, exp_code: 4'h7, exp_pred:  238, exp_step: 303};
    vecs[1] = '{pcm: -1000, exp_code: 4'hF, exp_pred: -330, exp_step: 724};
    vecs[2] = '{pcm:     0, exp_code: 4'h1, exp_pred:  -59, exp_step: 644};
    vecs[3] = '{pcm:   -59, exp_code: 4'h0, exp_pred:   21, exp_step: 573};

    // Reset state
    model_reset();
    #12;
    checkOutput("rst_code", int'(code), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_in_ready", int'(in_ready), 1);
    checkOutput("rst_pred", int'($signed(pred)), 0);
    checkOutput("rst_step", int'(step), 127);
    rst_n = 1'b1;
    tick();

    // Zero input from reset: step clamps back up to the minimum
    applyStimulus(0, 1'b0, c, p, s, lat);
    checkOutput("s1_code", c, 0);
    checkOutput("s1_pred", p, 15);
    checkOutput("s1_step", s, 127);
    checkOutput("s1_latency", lat, 5);
    checkOutput("s1_idle_after_ack", int'(in_ready), 1);
    checkOutput("s1_valid_after_ack", int'(out_valid), 0);

    // Hand-computed sequence from a cleared predictor
    do_clr();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(vecs[i].pcm, 1'b0, c, p, s, lat);
      checkOutput($sformatf("vec%0d_code", i), c, vecs[i].exp_code);
      checkOutput($sformatf("vec%0d_pred", i), p, vecs[i].exp_pred);
      checkOutput($sformatf("vec%0d_step", i), s, vecs[i].exp_step);
    end

    // Full-scale positive input: predictor climbs and pins at 7FFF
    do_clr();
    prev = 0; viol = 0;
    for (int i = 0; i < 40; i++) begin
      run_sample(32767, 1'b0, 1'b0, "s3p", dp);
      if (dp < prev) viol++;
      prev = dp;
    end
    checkOutput("s3p_monotonic_violations", viol, 0);
    checkOutput("s3p_final_pred", int'(pred), 16'h7FFF);

    // Full-scale negative input, then large alternating swings to push step
    // against its upper clamp
    do_clr();
    for (int i = 0; i < 40; i++) run_sample(-32768, 1'b0, 1'b0, "s3n", dp);
    do_clr();
    for (int i = 0; i < 20; i++)
      run_sample((i % 2) ? -32768 : 32767, 1'b0, 1'b0, "s3alt", dp);

    // Backpressure: output held, new input ignored, then exactly one code
    do_clr();
    run_sample(2000, 1'b0, 1'b0, "s4pre", dp);
    exp_c = model_code(-3000, mod_pred, mod_step);
    model_update(exp_c, mod_pred, mod_step);
    pcm_in = 16'(-3000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    checkOutput("s4_valid_rise", int'(out_valid), 1);
    checkOutput("s4_code", int'(code), exp_c);
    checkOutput("s4_pred", int'($signed(pred)), mod_pred);
    checkOutput("s4_step", int'(step), mod_step);
    hc = int'(code); hp = int'(pred); hs = int'(step);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      pcm_in = 16'($urandom);
      tick();
      if (int'(code) != hc || int'(pred) != hp || int'(step) != hs ||
          out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    in_valid = 1'b0;
    checkOutput("s4_hold_violations", bad, 0);
    cen = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    checkOutput("s4_cen0_hold_valid", int'(out_valid), 1);
    cen = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("s4_release_valid", int'(out_valid), 0);
    checkOutput("s4_release_ready", int'(in_ready), 1);
    extra = 0;
    repeat (10) begin
      tick();
      if (out_valid) extra++;
    end
    checkOutput("s4_extra_codes", extra, 0);
    run_sample(500, 1'b0, 1'b0, "s4post", dp);

    // clr while in B1 aborts the conversion
    pcm_in = 16'd5000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (2) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_reset();
    checkOutput("s5_clr_pred", int'(pred), 0);
    checkOutput("s5_clr_step", int'(step), 127);
    checkOutput("s5_clr_valid", int'(out_valid), 0);
    checkOutput("s5_clr_ready", int'(in_ready), 1);
    extra = 0;
    repeat (8) begin
      tick();
      if (out_valid) extra++;
    end
    checkOutput("s5_clr_stray", extra, 0);

    // Asynchronous reset while in UPD
    run_sample(1000, 1'b0, 1'b0, "s5pre", dp);
    pcm_in = 16'd7000;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s5_rst_pred", int'(pred), 0);
    checkOutput("s5_rst_step", int'(step), 127);
    checkOutput("s5_rst_valid", int'(out_valid), 0);
    checkOutput("s5_rst_ready", int'(in_ready), 1);
    #1 rst_n = 1'b1;
    model_reset();
    tick();
    applyStimulus(0, 1'b0, c, p, s, lat);
    checkOutput("s5_after_code", c, 0);
    checkOutput("s5_after_pred", p, 15);
    checkOutput("s5_after_step", s, 127);

    // Random stream with cen and out_ready gaps, cross-checked by the decoder
    do_clr();
    smp = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0)
        smp = int'($urandom_range(0, 65535)) - 32768;
      else begin
        smp = smp + int'($urandom_range(0, 8000)) - 4000;
        if (smp > 32767) smp = 32767;
        if (smp < -32768) smp = -32768;
      end
      run_sample(smp, 1'b1, 1'b1, "s6", dp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
